// File: rtl/fetch_assembler.sv
// 6502 instruction fetch/assembly stage: reads opcode and operand bytes and hands one whole instruction downstream.
// Optional illegal-opcode trap is enabled by defining FETCH_ILLEGAL_TRAP_EN.
module fetch_assembler #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [7:0]        out_op1,
  output logic [7:0]        out_op2,
  output logic [1:0]        out_len,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_illegal,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {FETCH, W_OPC, W_OP1, W_OP2, HOLD, TRAP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        opc_len;

  function automatic logic is_illegal(input logic [7:0] op);
    case (op[3:0])
      4'h0:    return op == 8'h80;
      4'h1, 4'h5, 4'h6, 4'h8, 4'hD: return 1'b0;
      4'h2:    return op != 8'hA2;
      4'h4:    return !(op inside {8'h24, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hE4});
      4'h9:    return op == 8'h89;
      4'hA:    return !(op inside {8'h0A, 8'h2A, 8'h4A, 8'h6A, 8'h8A,
                                   8'h9A, 8'hAA, 8'hBA, 8'hCA, 8'hEA});
      4'hC:    return !(op inside {8'h2C, 8'h4C, 8'h6C, 8'h8C,
                                   8'hAC, 8'hBC, 8'hCC, 8'hEC});
      4'hE:    return op == 8'h9E;
      default: return 1'b1;
    endcase
  endfunction

  // Unofficial opcodes always count as single-byte instructions.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    if (is_illegal(op)) return 2'd1;
    case (op[3:0])
      4'h0: begin
        if (op == 8'h20) return 2'd3;
        else if (op inside {8'h00, 8'h40, 8'h60}) return 2'd1;
        else return 2'd2;
      end
      4'h1, 4'h2, 4'h4, 4'h5, 4'h6: return 2'd2;
      4'h9:             return op[4] ? 2'd3 : 2'd2;
      4'hC, 4'hD, 4'hE: return 2'd3;
      default:          return 2'd1;
    endcase
  endfunction

  assign opc_len = op_len(mem_data);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    rd      = 1'b0;
    addr    = pc;
    case (state)
      FETCH: begin
        rd      = 1'b1;
        state_n = W_OPC;
      end
      W_OPC: begin
        if (opc_len != 2'd1) begin
          rd      = 1'b1;
          addr    = pc + ADDR_W'(1);
          state_n = W_OP1;
        end else begin
          state_n = HOLD;
        end
      end
      W_OP1: begin
        if (out_len == 2'd3) begin
          rd      = 1'b1;
          addr    = pc + ADDR_W'(2);
          state_n = W_OP2;
        end else begin
          state_n = HOLD;
        end
      end
      W_OP2: state_n = HOLD;
      HOLD: begin
        if (out_ready) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (out_illegal) begin
            state_n = TRAP;
          end else
`endif
          begin
            pc_n    = pc + ADDR_W'(out_len);
            rd      = 1'b1;
            addr    = pc + ADDR_W'(out_len);
            state_n = W_OPC;
          end
        end
      end
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
    // A redirect cancels whatever read this cycle would have issued.
    if (redirect_valid) begin
      state_n = FETCH;
      pc_n    = redirect_pc;
      rd      = 1'b0;
    end
  end

  assign mem_rd   = rst_n & rd;
  assign mem_addr = rst_n ? addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      out_valid  <= 1'b0;
      out_opcode <= 8'h00;
      out_op1    <= 8'h00;
      out_op2    <= 8'h00;
      out_len    <= 2'd1;
      out_pc     <= RESET_PC;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= (state_n == HOLD);
      if (!redirect_valid) begin
        case (state)
          W_OPC: begin
            out_opcode <= mem_data;
            out_op1    <= 8'h00;
            out_op2    <= 8'h00;
            out_len    <= opc_len;
            out_pc     <= pc;
          end
          W_OP1:   out_op1 <= mem_data;
          W_OP2:   out_op2 <= mem_data;
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_illegal <= 1'b0;
    else if (!redirect_valid && state == W_OPC) out_illegal <= is_illegal(mem_data);
  end
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_assembler.sv
// Directed self-checking bench for fetch_assembler with a one-cycle-latency byte memory model.
module tb_fetch_assembler;

  logic        clk;
  logic        rst_n;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode, out_op1, out_op2;
  logic [1:0]  out_len;
  logic [15:0] out_pc;
  logic        out_illegal;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [7:0]  mem [0:65535];
  int checks = 0;
  int errors = 0;

  fetch_assembler #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_op1(out_op1), .out_op2(out_op2),
    .out_len(out_len), .out_pc(out_pc), .out_illegal(out_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  function automatic logic [42:0] fields();
    return {out_valid, out_opcode, out_op1, out_op2, out_len, out_pc};
  endfunction

  function automatic logic [42:0] inst(input logic [7:0] op, input logic [7:0] o1,
                                       input logic [7:0] o2, input logic [1:0] len,
                                       input logic [15:0] pc);
    return {1'b1, op, o1, o2, len, pc};
  endfunction

  // Leaves the DUT freshly out of reset at a falling edge (cycle 0 = FETCH).
  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; out_ready = ready;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    #1;
    checks++;
    if ({mem_rd, mem_addr} !== 17'h0_0000) begin
      errors++; $display("[TB] FAIL reset_mem: got %h expected %h", {mem_rd, mem_addr}, 17'h0_0000);
    end
    checks++;
    if ({fields(), out_illegal} !== {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0}) begin
      errors++; $display("[TB] FAIL reset_out: got %h expected %h", {fields(), out_illegal},
                         {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("[TB] FAIL reset_first_read: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    end
  endtask

  task automatic test_run();
    do_reset(1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'h0001}) begin
      errors++; $display("[TB] FAIL run_op1_read: got %h expected %h", {out_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h0001});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fields() !== inst(8'hA9, 8'h42, 8'h00, 2'd2, 16'h0000)) begin
      errors++; $display("[TB] FAIL run_a9: got %h expected %h", fields(), inst(8'hA9, 8'h42, 8'h00, 2'd2, 16'h0000));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL run_valid_drop: got %b expected 0", out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fields() !== inst(8'h8D, 8'h00, 8'h02, 2'd3, 16'h0002)) begin
      errors++; $display("[TB] FAIL run_8d: got %h expected %h", fields(), inst(8'h8D, 8'h00, 8'h02, 2'd3, 16'h0002));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fields() !== inst(8'hE8, 8'h00, 8'h00, 2'd1, 16'h0005)) begin
      errors++; $display("[TB] FAIL run_e8: got %h expected %h", fields(), inst(8'hE8, 8'h00, 8'h00, 2'd1, 16'h0005));
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({fields(), mem_rd} !== {inst(8'hA9, 8'h42, 8'h00, 2'd2, 16'h0000), 1'b0}) begin
        errors++; $display("[TB] FAIL bp_hold%0d: got %h expected %h", k, {fields(), mem_rd},
                           {inst(8'hA9, 8'h42, 8'h00, 2'd2, 16'h0000), 1'b0});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0002}) begin
      errors++; $display("[TB] FAIL bp_release_read: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'h0002});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (fields() !== inst(8'h8D, 8'h00, 8'h02, 2'd3, 16'h0002)) begin
      errors++; $display("[TB] FAIL bp_next: got %h expected %h", fields(), inst(8'h8D, 8'h00, 8'h02, 2'd3, 16'h0002));
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0004}) begin
      errors++; $display("[TB] FAIL redir_op2_read: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'h0004});
    end
    redirect_valid = 1'b1; redirect_pc = 16'h8000;
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin
      errors++; $display("[TB] FAIL redir_suppress: got %b expected 0", mem_rd);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'h8000}) begin
      errors++; $display("[TB] FAIL redir_fetch: got %h expected %h", {out_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h8000});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL redir_no_8d: got %b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (fields() !== inst(8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000)) begin
      errors++; $display("[TB] FAIL redir_ea: got %h expected %h", fields(), inst(8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000));
    end
  endtask

  task automatic test_wrap();
    mem[16'h0000] = 8'h7F;
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("[TB] FAIL wrap_fetch: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'hFFFF});
    end
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("[TB] FAIL wrap_op1_addr: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fields() !== inst(8'hA9, 8'h7F, 8'h00, 2'd2, 16'hFFFF)) begin
      errors++; $display("[TB] FAIL wrap_inst: got %h expected %h", fields(), inst(8'hA9, 8'h7F, 8'h00, 2'd2, 16'hFFFF));
    end
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0001}) begin
      errors++; $display("[TB] FAIL wrap_next_pc: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'h0001});
    end
    mem[16'h0000] = 8'hA9;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 16'h8000;
    @(negedge clk);
    redirect_pc = 16'h1234;
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_suppress: got %b expected 0", mem_rd);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h1234}) begin
      errors++; $display("[TB] FAIL b2b_last_wins: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'h1234});
    end
  endtask

  task automatic test_illegal();
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (fields() !== inst(8'h02, 8'h00, 8'h00, 2'd1, 16'h0010)) begin
      errors++; $display("[TB] FAIL illegal_inst: got %h expected %h", fields(), inst(8'h02, 8'h00, 8'h00, 2'd1, 16'h0010));
    end
`ifdef FETCH_ILLEGAL_TRAP_EN
    checks++;
    if ({out_illegal, mem_rd} !== 2'b10) begin
      errors++; $display("[TB] FAIL trap_flag: got %b expected 10", {out_illegal, mem_rd});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, mem_rd} !== 2'b00) begin
        errors++; $display("[TB] FAIL trap_idle%0d: got %b expected 00", k, {out_valid, mem_rd});
      end
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("[TB] FAIL trap_exit: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    end
`else
    checks++;
    if ({out_illegal, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'h0011}) begin
      errors++; $display("[TB] FAIL illegal_resume: got %h expected %h", {out_illegal, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h0011});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fields() !== inst(8'hE8, 8'h00, 8'h00, 2'd1, 16'h0011)) begin
      errors++; $display("[TB] FAIL illegal_next: got %h expected %h", fields(), inst(8'hE8, 8'h00, 8'h00, 2'd1, 16'h0011));
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (out_opcode !== 8'h8D) begin
      errors++; $display("[TB] FAIL mid_setup: got %h expected 8d", out_opcode);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fields(), mem_rd} !== {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0}) begin
      errors++; $display("[TB] FAIL mid_async: got %h expected %h", {fields(), mem_rd},
                         {1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++; $display("[TB] FAIL mid_restart: got %h expected %h", {out_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h0000});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fields() !== inst(8'hA9, 8'h42, 8'h00, 2'd2, 16'h0000)) begin
      errors++; $display("[TB] FAIL mid_rerun: got %h expected %h", fields(), inst(8'hA9, 8'h42, 8'h00, 2'd2, 16'h0000));
    end
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h42; mem[16'h0002] = 8'h8D;
    mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h02; mem[16'h0005] = 8'hE8;
    mem[16'h0010] = 8'h02; mem[16'h0011] = 8'hE8;
    mem[16'h8000] = 8'hEA; mem[16'hFFFF] = 8'hA9;
    $display("[TB] starting fetch_assembler bench");
    test_reset();
    test_run();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_assembler.md
Name: fetch_assembler

Overview:
- Instruction fetch stage directly upstream of the 6502 decoder/execute core in the NES CPU.
- Reads opcode and operand bytes from the byte-wide synchronous memory and computes instruction length from the opcode.
- Presents one complete instruction (opcode, operand bytes, PC, length) per transfer over a valid/ready handshake.
- Accepts PC redirects for branches, jumps and interrupts.

Parameters:
- ADDR_W, 16, address and PC width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_rd  output  1  read strobe; data returns on mem_data exactly one cycle later.
- mem_addr  output  ADDR_W  read address.
- mem_data  input  8  read data, valid the cycle after mem_rd.
- out_valid  output  1  assembled instruction available.
- out_ready  input  1  consumer accepts the instruction.
- out_opcode  output  8  opcode byte.
- out_op1  output  8  first operand byte; 0 if unused.
- out_op2  output  8  second operand byte; 0 if unused.
- out_len  output  2  instruction length, 1..3.
- out_pc  output  ADDR_W  address of the opcode.
- out_illegal  output  1  opcode is unofficial (see Optional Feature).
- redirect_valid  input  1  load a new PC.
- redirect_pc  input  ADDR_W  target PC.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=FETCH, pc=RESET_PC.
  - mem_rd=0, mem_addr=0, out_valid=0.
  - out_opcode/op1/op2=0, out_len=1, out_pc=RESET_PC, out_illegal=0.
- Outputs are registered. mem_rd and mem_addr are decoded from state and pc.
- FETCH: mem_rd=1, mem_addr=pc; goes to W_OPC.
- W_OPC:
  - Latch mem_data into out_opcode; clear op1/op2; compute len.
  - If len>1: issue a read at pc+1 in the same cycle and go to W_OP1. Otherwise go to HOLD.
- W_OP1:
  - Latch op1.
  - If len==3: issue a read at pc+2 and go to W_OP2. Otherwise go to HOLD.
- W_OP2: latch op2; go to HOLD.
- HOLD:
  - out_valid=1. All out_* fields stay stable while out_ready=0.
  - On out_ready=1: pc<=pc+len, issue a read at pc+len in the same cycle, go to W_OPC.
- Throughput with out_ready tied high: 1-byte=2 clk, 2-byte=3 clk, 3-byte=4 clk per instruction.
- Length decode:
  - 00/40/60 → 1; 20 → 3.
  - Low nibble 0: odd high nibble (branches) → 2; A0/C0/E0 → 2; other → illegal.
  - Low nibble 1/4/5/6 → 2 (04/0x44/64/14/34/54/74/D4/F4/x4 unofficial → illegal).
  - 8, A → 1 (x8 all official; xA official only for 0A/2A/4A/6A/8A/9A/AA/BA/CA/EA).
  - 9: even high nibble → 2, odd high nibble → 3 (89 illegal).
  - C/D/E → 3 (official subset only).
  - 2: only A2 official → 2.
  - 3/7/B/F → illegal.
  - Illegal opcodes → len=1.
- Address arithmetic is modulo 2^ADDR_W: operand fetch at FFFF+1 reads 0000; pc+len wraps.
- Redirect (any state, highest priority):
  - pc<=redirect_pc and state<=FETCH; out_valid=0 from the next cycle.
  - Any read in flight is discarded; mem_data the following cycle is ignored.
  - Redirect in HOLD with out_ready=1: the transfer completes (consumer took it), but no read at pc+len is issued.
  - Redirect during W_OP1/W_OP2: the partial instruction is dropped.
- Redirect asserted in back-to-back cycles: the last one wins.
- Reset mid-instruction: immediate return to reset values; no output glitch past reset deassertion.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode is presented in HOLD with out_illegal=1 and len=1.
  - After acceptance, the FSM enters TRAP: no reads, out_valid=0.
  - TRAP exits only on redirect or reset.
- Undefined:
  - out_illegal is tied 0.
  - Illegal opcodes are issued as 1-byte instructions and fetch continues at pc+1.

Test Plan:
- Reset then run. Memory 0000: A9 42 8D 00 02 E8, out_ready=1.
  - Expect: {A9,42,00,len2,pc0000} at clk3; {8D,00,02,len3,pc0002} at clk7; {E8,len1,pc0005} at clk9.
- Backpressure. Hold out_ready=0 for 5 clk on the A9 instruction.
  - Expect: fields stable, mem_rd=0 during HOLD; a read at 0002 issued in the cycle out_ready rises.
- Redirect. Assert redirect_valid with redirect_pc=8000 during W_OP1 of 8D; memory 8000: EA.
  - Expect: 8D never presented; next transfer {EA,len1,pc8000}.
- Wrap. redirect_pc=FFFF, memory FFFF: A9, 0000: 7F.
  - Expect: {A9,7F,len2,pcFFFF}; next fetch at 0001.
- Illegal trap with FETCH_ILLEGAL_TRAP_EN defined. Opcode 02 at 0010.
  - Expect: out_illegal=1; then mem_rd stays 0 until redirect.
  - With the macro undefined: presented as len1, fetch resumes at 0011.
- Asynchronous reset mid-W_OP2 (rst_n low 1 clk).
  - Expect: out_valid=0 immediately; first read after release at 0000.
